fetch: RTL and testbench

Instruction fetch stage: produces `inst` and `if_pc` for the decode stage from a synchronous instruction BRAM, and services PC redirects from execute. A small credit-controlled instruction queue decouples the BRAM address path from the late stall signals (`n_stall`, `dec_nstall`), so neither stall signal ever reaches `imem_addr` combinationally. An empty queue presents the canonical NOP (`32'h0`) to decode.

---
 rtl/core_pkg.sv | 10 +
 rtl/inst_queue.sv | 41 ++++
 rtl/fetch.sv | 63 ++++++
 tb/tb_fetch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch-stage types and constants
// Provides the PC word-address width, the canonical NOP and the queue entry type.
package core_pkg;
  localparam int PC_W = 25;
  localparam logic [31:0] NOP_INST = 32'h0;
  typedef struct packed {
    logic [31:0] inst;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of fetch entries with clear
// Ports: clk, rst (async active-low), clr (empties queue, wins over push/pop),
// push/din (enqueue), pop (dequeue), head (oldest entry), occ (occupancy).
module inst_queue import core_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [OW-1:0] occ
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && !clr) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  occ_bound: assert property (@(posedge clk) disable iff (!rst) occ <= OW'(DEPTH));
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage with credit-controlled queue in front of decode
// Ports: clk, rst (async active-low); imem_en/imem_addr/imem_data (sync BRAM,
// one-cycle read latency); n_stall/dec_nstall (late stalls, only gate the pop);
// redirect/redirect_pc (execute-resolved target); inst/if_pc/if_valid (queue head
// to decode, NOP and PC 0 when empty).
module fetch #(
  parameter int DEPTH = 4,
  parameter int PC_W = core_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            n_stall,
  input  logic            dec_nstall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid
);
  localparam int OW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] fetch_pc, inflight_pc;
  logic inflight, squash, push, pop;
  logic [OW-1:0] occ;
  core_pkg::fetch_entry_t head;
  // Every in-flight read owns a queue slot, so the queue can never overflow and
  // the stall inputs never need to reach the address path.
  assign imem_en = rst & ~redirect & (({1'b0, occ} + {{OW{1'b0}}, inflight}) < (OW + 1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign push = inflight & ~squash & ~redirect;
  assign pop = n_stall & dec_nstall & (occ != '0);
  assign if_valid = occ != '0;
  assign inst = if_valid ? head.inst : core_pkg::NOP_INST;
  assign if_pc = if_valid ? head.pc : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      squash <= 1'b0;
    end else begin
      squash <= redirect;
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + PC_W'(1);
      end
      if (redirect) fetch_pc <= redirect_pc;
    end
  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .clr(redirect),
    .push(push),
    .pop(pop),
    .din('{inst: imem_data, pc: inflight_pc}),
    .head(head),
    .occ(occ)
  );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch stage
module tb_fetch;
  logic clk = 1'b0;
  logic rst;
  logic imem_en;
  logic [24:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic n_stall, dec_nstall, redirect;
  logic [24:0] redirect_pc;
  logic [31:0] inst;
  logic [24:0] if_pc;
  logic if_valid;
  int checks = 0;
  int errors = 0;
  fetch dut (
    .clk(clk),
    .rst(rst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .n_stall(n_stall),
    .dec_nstall(dec_nstall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst(inst),
    .if_pc(if_pc),
    .if_valid(if_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (imem_en) imem_data <= 32'h100 + {7'b0, imem_addr};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_head(input string tag, input logic [24:0] pc, input logic [31:0] word);
    chk({tag, "_pc"}, 64'(if_pc), 64'(pc));
    chk({tag, "_inst"}, 64'(inst), 64'(word));
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, 64'(imem_en), 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_pc"}, 64'(if_pc), 64'd0);
    chk({tag, "_valid"}, 64'(if_valid), 64'd0);
  endtask
  task automatic restart(input string tag);
    nxt;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_c0_en"}, 64'(imem_en), 64'd1);
    chk({tag, "_c0_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_c0_valid"}, 64'(if_valid), 64'd0);
    nxt;
    @(negedge clk);
    chk({tag, "_c1_valid"}, 64'(if_valid), 64'd0);
  endtask
  initial begin
    rst = 1'b0;
    n_stall = 1'b1;
    dec_nstall = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    restart("start");
    for (int c = 2; c <= 4; c++) begin
      nxt;
      @(negedge clk);
      chk_head("stream", 25'(c - 2), 32'h100 + 32'(c - 2));
    end
    nxt;
    dec_nstall = 1'b0;
    @(negedge clk);
    chk_head("stall_c5", 25'd3, 32'h103);
    for (int c = 6; c <= 9; c++) begin
      nxt;
      @(negedge clk);
      chk_head("stall_hold", 25'd3, 32'h103);
      chk("stall_en", 64'(imem_en), c == 6 ? 64'd1 : 64'd0);
    end
    nxt;
    dec_nstall = 1'b1;
    @(negedge clk);
    chk_head("resume_c10", 25'd3, 32'h103);
    for (int c = 11; c <= 15; c++) begin
      nxt;
      @(negedge clk);
      chk_head("resume", 25'(c - 7), 32'h100 + 32'(c - 7));
    end
    nxt;
    redirect = 1'b1;
    redirect_pc = 25'h40;
    @(negedge clk);
    chk("redir_r_en", 64'(imem_en), 64'd0);
    nxt;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_r1_en", 64'(imem_en), 64'd1);
    chk("redir_r1_addr", 64'(imem_addr), 64'h40);
    chk("redir_r1_valid", 64'(if_valid), 64'd0);
    nxt;
    @(negedge clk);
    chk("redir_r2_addr", 64'(imem_addr), 64'h41);
    chk("redir_r2_valid", 64'(if_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      nxt;
      @(negedge clk);
      chk_head("redir_tgt", 25'h40 + 25'(k), 32'h140 + 32'(k));
    end
    nxt;
    redirect = 1'b1;
    n_stall = 1'b0;
    redirect_pc = 25'h1FFFFFF;
    @(negedge clk);
    chk("stallredir_en", 64'(imem_en), 64'd0);
    nxt;
    redirect = 1'b0;
    n_stall = 1'b1;
    @(negedge clk);
    chk("stallredir_valid", 64'(if_valid), 64'd0);
    chk("wrap_addr", 64'(imem_addr), 64'h1FFFFFF);
    nxt;
    @(negedge clk);
    chk("wrap_addr_next", 64'(imem_addr), 64'h0);
    nxt;
    @(negedge clk);
    chk_head("wrap0", 25'h1FFFFFF, 32'h20000FF);
    nxt;
    @(negedge clk);
    chk_head("wrap1", 25'h0, 32'h100);
    nxt;
    @(negedge clk);
    chk_head("wrap2", 25'h1, 32'h101);
    #1;
    rst = 1'b0;
    #1;
    chk_idle("async_rst");
    restart("rerun");
    for (int c = 2; c <= 3; c++) begin
      nxt;
      @(negedge clk);
      chk_head("rerun", 25'(c - 2), 32'h100 + 32'(c - 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
